// File: rtl/adder_operand_collector.sv
// Packs a valid/ready byte stream into zero-padded groups of four for the four-operand adder.
// A group is presented one cycle after its closing word is accepted; input stalls while a group is held.
module adder_operand_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [2:0]       out_count,
  output logic [CNT_W-1:0] group_count
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] idx;
  logic       accept;
  logic       close_grp;
  logic       handoff;

  assign accept    = in_valid & in_ready;
  assign close_grp = accept & ((idx == 2'd3) | in_last);
  assign handoff   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (close_grp) next_state = HOLD;
      HOLD:    if (handoff)   next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // in_ready is forced low during reset so no word is accepted into a group being discarded.
  always_comb begin
    in_ready  = (state == COLLECT) & ~rst;
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= 2'd0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      out_count   <= 3'd0;
      group_count <= '0;
    end else if (handoff) begin
      // Clearing the slots here is what zero-pads the next short group.
      idx         <= 2'd0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      out_count   <= 3'd0;
      group_count <= group_count + 1'b1;
    end else if (accept) begin
      case (idx)
        2'd0:    a <= in_data;
        2'd1:    b <= in_data;
        2'd2:    c <= in_data;
        default: d <= in_data;
      endcase
      idx <= idx + 2'd1;
      if (close_grp) out_count <= {1'b0, idx} + 3'd1;
    end
  end

endmodule
